// File: rtl/power_op_scheduler.sv
// Round-robin arbiter and sequencer that shares one WIDTH-bit multiplier among NREQ
// requesters to compute it^n, n*it^(n-1) and (i*n*it^(n-1))^n, one multiply per cycle.
module power_op_scheduler #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SCALAR_SIZE = 24,
    parameter int unsigned NREQ        = 4,
    parameter int unsigned IDW         = $clog2(NREQ)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*SCALAR_SIZE-1:0] req_field,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        abort,
    output logic                        busy,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [IDW-1:0]              resp_id,
    output logic [WIDTH-1:0]            f_it,
    output logic [WIDTH-1:0]            f_prime_it,
    output logic [WIDTH-1:0]            result
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_POW1,
        S_FIT,
        S_FPR,
        S_MULI,
        S_POW2,
        S_ZERO,
        S_DONE
    } state_t;

    state_t                 state;
    logic [IDW-1:0]         rr_ptr;
    logic [IDW-1:0]         id_q;
    logic [7:0]             i_q;
    logic [7:0]             it_q;
    logic [7:0]             n_q;
    logic [7:0]             cnt;
    logic [WIDTH-1:0]       acc;
    logic [WIDTH-1:0]       f_q;
    logic [WIDTH-1:0]       fp_q;
    logic [WIDTH-1:0]       x_q;

    logic [NREQ-1:0]        grant;
    logic [IDW-1:0]         win_idx;
    logic [IDW-1:0]         win_next;
    logic [SCALAR_SIZE-1:0] win_field;
    logic                   found;
    int unsigned            scan_pos;

    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic [WIDTH-1:0]       mul_p;
    logic                   accept;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ; only offered in IDLE.
    always_comb begin
        grant     = '0;
        win_idx   = '0;
        win_next  = '0;
        win_field = '0;
        found     = 1'b0;
        scan_pos  = 0;
        if (state == S_IDLE && reset_n) begin
            for (int j = 0; j < NREQ; j++) begin
                scan_pos = 32'(rr_ptr) + 32'(j);
                if (scan_pos >= NREQ) begin
                    scan_pos = scan_pos - NREQ;
                end
                if (!found && req_valid[scan_pos[IDW-1:0]]) begin
                    grant[scan_pos[IDW-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                if (grant[k]) begin
                    win_field = req_field[k*SCALAR_SIZE +: SCALAR_SIZE];
                    win_idx   = IDW'(k);
                    win_next  = (k == NREQ - 1) ? '0 : IDW'(k + 1);
                end
            end
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign busy      = (state != S_IDLE);

    // Operand steering for the single shared multiplier; products wrap mod 2^WIDTH.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_POW1, S_FIT: begin
                mul_a = acc;
                mul_b = WIDTH'(it_q);
            end
            S_FPR: begin
                mul_a = WIDTH'(n_q);
                mul_b = acc;
            end
            S_MULI: begin
                mul_a = WIDTH'(i_q);
                mul_b = fp_q;
            end
            S_POW2: begin
                mul_a = acc;
                mul_b = x_q;
            end
            default: ;
        endcase
    end

    assign mul_p = mul_a * mul_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            i_q        <= '0;
            it_q       <= '0;
            n_q        <= '0;
            cnt        <= '0;
            acc        <= '0;
            f_q        <= '0;
            fp_q       <= '0;
            x_q        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            f_it       <= '0;
            f_prime_it <= '0;
            result     <= '0;
        end else if (abort && state != S_IDLE) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        i_q    <= win_field[23:16];
                        it_q   <= win_field[15:8];
                        n_q    <= win_field[7:0];
                        id_q   <= win_idx;
                        rr_ptr <= win_next;
                        state  <= S_LOAD;
                    end
                end
                // acc starts at it^0 so n-1 POW1 steps leave it^(n-1)
                S_LOAD: begin
                    if (n_q == 8'd0) begin
                        state <= S_ZERO;
                    end else begin
                        acc   <= WIDTH'(1);
                        cnt   <= n_q - 8'd1;
                        state <= (n_q == 8'd1) ? S_FIT : S_POW1;
                    end
                end
                S_POW1: begin
                    acc <= mul_p;
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state <= S_FIT;
                    end
                end
                S_FIT: begin
                    f_q   <= mul_p;
                    state <= S_FPR;
                end
                S_FPR: begin
                    fp_q  <= mul_p;
                    state <= S_MULI;
                end
                S_MULI: begin
                    x_q   <= mul_p;
                    acc   <= WIDTH'(1);
                    cnt   <= n_q;
                    state <= S_POW2;
                end
                S_POW2: begin
                    acc <= mul_p;
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state      <= S_DONE;
                        resp_valid <= 1'b1;
                        resp_id    <= id_q;
                        f_it       <= f_q;
                        f_prime_it <= fp_q;
                        result     <= mul_p;
                    end
                end
                // n==0 shortcut, one extra cycle keeps its latency at two edges
                S_ZERO: begin
                    state      <= S_DONE;
                    resp_valid <= 1'b1;
                    resp_id    <= id_q;
                    f_it       <= WIDTH'(1);
                    f_prime_it <= '0;
                    result     <= WIDTH'(1);
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_power_op_scheduler.sv
// Directed bench for power_op_scheduler: arbitration order, latency, results against a
// mod-2^32 model, backpressure, abort and mid-operation reset.
module tb_power_op_scheduler;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SS    = 24;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*SS-1:0]   req_field;
    logic [NREQ-1:0]      req_ready;
    logic                 abort;
    logic                 busy;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [WIDTH-1:0]     f_it;
    logic [WIDTH-1:0]     f_prime_it;
    logic [WIDTH-1:0]     result;

    int errors = 0;
    int checks = 0;

    power_op_scheduler #(
        .WIDTH(WIDTH), .SCALAR_SIZE(SS), .NREQ(NREQ), .IDW(IDW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_field(req_field),
        .req_ready(req_ready), .abort(abort), .busy(busy), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_id(resp_id), .f_it(f_it), .f_prime_it(f_prime_it),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pw(input logic [31:0] b, input int e);
        logic [31:0] r;
        r = 32'd1;
        for (int j = 0; j < e; j++) r = r * b;
        return r;
    endfunction

    function automatic void model(input logic [7:0] i, input logic [7:0] it, input logic [7:0] n,
                                  output logic [31:0] f, output logic [31:0] fp,
                                  output logic [31:0] r);
        f  = pw(32'(it), int'(n));
        fp = (n == 8'd0) ? 32'd0 : 32'(n) * pw(32'(it), int'(n) - 1);
        r  = pw(32'(i) * fp, int'(n));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        req_valid  = '0;
        abort      = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic accept_one(input int k, input logic [7:0] i, input logic [7:0] it,
                              input logic [7:0] n, input string tag);
        logic [NREQ-1:0] e;
        @(negedge clk);
        req_valid    = '0;
        req_valid[k] = 1'b1;
        req_field[k*SS +: SS] = {i, it, n};
        e    = '0;
        e[k] = 1'b1;
        #1 check({tag, " ready"}, 64'(req_ready), 64'(e));
        @(posedge clk);
        #1 req_valid = '0;
        check({tag, " busy"}, 64'(busy), 64'd1);
    endtask

    task automatic issue(input int k, input logic [7:0] i, input logic [7:0] it,
                         input logic [7:0] n, input int hold, input string tag);
        logic [31:0] ef, efp, er;
        int waited;
        int lat;
        model(i, it, n, ef, efp, er);
        lat = (n == 8'd0) ? 2 : 2 * int'(n) + 3;
        accept_one(k, i, it, n, tag);
        waited = 0;
        while (!resp_valid && waited < 600) begin
            @(posedge clk);
            #1 waited++;
        end
        check({tag, " latency"}, 64'(waited), 64'(lat));
        check({tag, " f_it"}, 64'(f_it), 64'(ef));
        check({tag, " f_prime_it"}, 64'(f_prime_it), 64'(efp));
        check({tag, " result"}, 64'(result), 64'(er));
        check({tag, " resp_id"}, 64'(resp_id), 64'(k));
        if (hold > 0) begin
            req_valid = '1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                check({tag, " hold ready"}, 64'(req_ready), 64'd0);
                check({tag, " hold valid"}, 64'(resp_valid), 64'd1);
                check({tag, " hold result"}, 64'(result), 64'(er));
                check({tag, " hold f_it"}, 64'(f_it), 64'(ef));
            end
            req_valid = '0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check({tag, " handoff valid"}, 64'(resp_valid), 64'd0);
        check({tag, " handoff busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] ef, efp, er;
        logic [NREQ-1:0] e;
        int waited;
        int cnt_v;

        // reset held with random inputs
        reset_n    = 1'b0;
        req_valid  = '0;
        req_field  = '0;
        abort      = 1'b0;
        resp_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            req_valid  = 4'($urandom);
            req_field  = {$urandom, $urandom, $urandom};
            abort      = 1'($urandom);
            resp_ready = 1'($urandom);
            #1;
            check("reset ctl", 64'({req_ready, resp_valid, busy, resp_id}), 64'd0);
            check("reset f", 64'({f_it, f_prime_it}), 64'd0);
            check("reset result", 64'(result), 64'd0);
        end
        @(negedge clk);
        abort      = 1'b0;
        resp_ready = 1'b0;
        req_valid  = 4'b1111;
        reset_n    = 1'b1;
        #1 check("post-reset arb all", 64'(req_ready), 64'h1);
        req_valid = 4'b0110;
        #1 check("post-reset arb 1,2", 64'(req_ready), 64'h2);
        req_valid = '0;

        issue(0, 8'd1, 8'd2, 8'd3, 0, "single");
        issue(1, 8'd5, 8'd7, 8'd0, 0, "n0");
        issue(2, 8'd3, 8'd9, 8'd1, 0, "n1");

        // round-robin with everyone requesting and the consumer always ready
        do_reset();
        for (int k = 0; k < NREQ; k++) req_field[k*SS +: SS] = {8'(k + 1), 8'(k + 2), 8'd2};
        @(negedge clk);
        resp_ready = 1'b1;
        req_valid  = '1;
        #1;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            while (req_ready == '0 && waited < 50) begin
                @(posedge clk);
                #1 waited++;
            end
            e = '0;
            e[g % NREQ] = 1'b1;
            check("rr grant", 64'(req_ready), 64'(e));
            @(posedge clk);
            #1 waited = 0;
            while (!resp_valid && waited < 50) begin
                @(posedge clk);
                #1 waited++;
            end
            model(8'((g % NREQ) + 1), 8'((g % NREQ) + 2), 8'd2, ef, efp, er);
            check("rr resp_id", 64'(resp_id), 64'(g % NREQ));
            check("rr result", 64'(result), 64'(er));
            @(posedge clk);
            #1 check("rr one-cycle handoff", 64'(resp_valid), 64'd0);
        end
        req_valid  = '0;
        resp_ready = 1'b0;
        do_reset();

        // backpressure: ten cycles held in DONE with all requesters asking
        issue(0, 8'd2, 8'd3, 8'd2, 10, "backpressure");

        // abort in POW1; rr_ptr must stay advanced past requester 1
        accept_one(1, 8'd1, 8'd2, 8'd5, "abort op");
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort resp_valid", 64'(resp_valid), 64'd0);
        cnt_v = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1 if (resp_valid) cnt_v++;
        end
        check("abort no response", 64'(cnt_v), 64'd0);
        check("abort keeps f_it", 64'(f_it), 64'd9);

        // abort while IDLE is ignored; then reset lands in POW2
        @(negedge clk);
        req_valid = 4'b0111;
        #1 check("rr after abort", 64'(req_ready), 64'h4);
        req_field[2*SS +: SS] = {8'd2, 8'd3, 8'd4};
        req_valid = 4'b0100;
        abort     = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        req_valid = '0;
        check("abort in idle ignored", 64'(busy), 64'd1);
        repeat (8) @(posedge clk);
        #1 check("in pow2 busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("midop reset ctl", 64'({req_ready, resp_valid, busy, resp_id}), 64'd0);
        check("midop reset f_it", 64'(f_it), 64'd0);
        check("midop reset result", 64'(result), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        issue(3, 8'd255, 8'd255, 8'd255, 0, "wrap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
